// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Optional hit/miss/writeback counters are enabled with DCACHE_WB_STATS_EN.
module dcache_wb #(
    parameter int unsigned NUM_LINES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_read_en,
    input  logic         in_write_en,
    input  logic [31:0]  in_addr,
    input  logic [31:0]  in_write_data,
    input  logic [3:0]   in_byte_en,
    output logic [31:0]  out_read_data,
    output logic         out_stall,
    output logic         out_mem_read_en,
    output logic         out_mem_write_en,
    output logic [31:0]  out_mem_addr,
    output logic [127:0] out_mem_write_data,
    input  logic [127:0] in_mem_read_data,
    input  logic         in_mem_ready
`ifdef DCACHE_WB_STATS_EN
    ,
    output logic [31:0]  out_hit_count,
    output logic [31:0]  out_miss_count,
    output logic [31:0]  out_wb_count
`endif
);

    localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned TAG_W    = 32 - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        S_LOOKUP    = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2,
        S_RESPOND   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [127:0]         r_data  [NUM_LINES];
    logic [TAG_W-1:0]     r_tag   [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    logic [1:0]         w_word;
    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_req;
    logic               w_is_load;
    logic               w_hit;
    logic               w_lookup_hit;
    logic               w_miss;
    logic               w_store_commit;
    logic [127:0]       w_line;
    logic [31:0]        w_word_rd;
    logic [31:0]        w_byte_mask;
    logic [127:0]       w_new_line;
    logic               w_unused;

    assign w_word    = in_addr[3:2];
    assign w_index   = in_addr[OFFSET_W +: INDEX_W];
    assign w_tag     = in_addr[31 -: TAG_W];
    assign w_unused  = ^in_addr[1:0];
    assign w_req     = in_read_en | in_write_en;
    assign w_is_load = in_read_en & ~in_write_en;

    assign w_line       = r_data[w_index];
    assign w_word_rd    = w_line[{w_word, 5'b0} +: 32];
    assign w_hit        = w_req & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_lookup_hit = ~reset & (r_state == S_LOOKUP) & w_hit;
    assign w_miss       = ~reset & (r_state == S_LOOKUP) & w_req & ~w_hit;

    // Stores commit on a lookup hit or in the cycle after a refill.
    assign w_store_commit = ~reset & in_write_en &
                            ((r_state == S_LOOKUP && w_hit) || r_state == S_RESPOND);

    assign w_byte_mask = {{8{in_byte_en[3]}}, {8{in_byte_en[2]}},
                          {8{in_byte_en[1]}}, {8{in_byte_en[0]}}};

    // Line with the enabled store bytes merged into the selected word.
    always_comb begin
        w_new_line = w_line;
        w_new_line[{w_word, 5'b0} +: 32] = (w_word_rd & ~w_byte_mask) |
                                           (in_write_data & w_byte_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOOKUP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and all core/memory-facing outputs.
    always_comb begin
        w_next_state       = r_state;
        out_stall          = 1'b0;
        out_read_data      = 32'h0;
        out_mem_read_en    = 1'b0;
        out_mem_write_en   = 1'b0;
        out_mem_addr       = 32'h0;
        out_mem_write_data = 128'h0;
        case (r_state)
            S_LOOKUP: begin
                if (w_req && !w_hit) begin
                    out_stall    = 1'b1;
                    w_next_state = (r_valid[w_index] && r_dirty[w_index]) ?
                                   S_WRITEBACK : S_REFILL;
                end else if (w_hit && w_is_load) begin
                    out_read_data = w_word_rd;
                end
            end
            S_WRITEBACK: begin
                out_stall          = 1'b1;
                out_mem_write_en   = ~in_mem_ready;
                out_mem_addr       = {r_tag[w_index], w_index, 4'b0};
                out_mem_write_data = w_line;
                if (in_mem_ready) begin
                    w_next_state = S_REFILL;
                end
            end
            S_REFILL: begin
                out_stall       = 1'b1;
                out_mem_read_en = ~in_mem_ready;
                out_mem_addr    = {w_tag, w_index, 4'b0};
                if (in_mem_ready) begin
                    w_next_state = S_RESPOND;
                end
            end
            S_RESPOND: begin
                w_next_state = S_LOOKUP;
                if (w_is_load) begin
                    out_read_data = w_word_rd;
                end
            end
            default: w_next_state = S_LOOKUP;
        endcase
        // Reset forces idle outputs immediately so memory never sees a stale enable.
        if (reset) begin
            w_next_state       = S_LOOKUP;
            out_stall          = 1'b0;
            out_read_data      = 32'h0;
            out_mem_read_en    = 1'b0;
            out_mem_write_en   = 1'b0;
            out_mem_addr       = 32'h0;
            out_mem_write_data = 128'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            case (r_state)
                S_LOOKUP: begin
                    if (w_store_commit) r_dirty[w_index] <= 1'b1;
                end
                S_WRITEBACK: begin
                    if (in_mem_ready) r_dirty[w_index] <= 1'b0;
                end
                S_REFILL: begin
                    if (in_mem_ready) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                    end
                end
                S_RESPOND: begin
                    if (w_store_commit) r_dirty[w_index] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Data and tag arrays carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (!reset && r_state == S_REFILL && in_mem_ready) begin
            r_data[w_index] <= in_mem_read_data;
            r_tag[w_index]  <= w_tag;
        end else if (w_store_commit) begin
            r_data[w_index] <= w_new_line;
        end
    end

`ifdef DCACHE_WB_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic [31:0] r_wb_count;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= 32'h0;
            r_miss_count <= 32'h0;
            r_wb_count   <= 32'h0;
        end else begin
            if (w_lookup_hit && r_hit_count != 32'hFFFF_FFFF)
                r_hit_count <= r_hit_count + 32'd1;
            if (w_miss && r_miss_count != 32'hFFFF_FFFF)
                r_miss_count <= r_miss_count + 32'd1;
            if (r_state == S_WRITEBACK && in_mem_ready && r_wb_count != 32'hFFFF_FFFF)
                r_wb_count <= r_wb_count + 32'd1;
        end
    end

    assign out_hit_count  = r_hit_count;
    assign out_miss_count = r_miss_count;
    assign out_wb_count   = r_wb_count;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Testbench for dcache_wb: 10-cycle memory model, vector table plus reset-in-refill sequence.
module tb_dcache_wb;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_read_en;
    logic         in_write_en;
    logic [31:0]  in_addr;
    logic [31:0]  in_write_data;
    logic [3:0]   in_byte_en;
    logic [31:0]  out_read_data;
    logic         out_stall;
    logic         out_mem_read_en;
    logic         out_mem_write_en;
    logic [31:0]  out_mem_addr;
    logic [127:0] out_mem_write_data;
    logic [127:0] in_mem_read_data;
    logic         in_mem_ready;
`ifdef DCACHE_WB_STATS_EN
    logic [31:0]  out_hit_count;
    logic [31:0]  out_miss_count;
    logic [31:0]  out_wb_count;
`endif

    always #5 clk = ~clk;

    dcache_wb #(.NUM_LINES(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_read_en         (in_read_en),
        .in_write_en        (in_write_en),
        .in_addr            (in_addr),
        .in_write_data      (in_write_data),
        .in_byte_en         (in_byte_en),
        .out_read_data      (out_read_data),
        .out_stall          (out_stall),
        .out_mem_read_en    (out_mem_read_en),
        .out_mem_write_en   (out_mem_write_en),
        .out_mem_addr       (out_mem_addr),
        .out_mem_write_data (out_mem_write_data),
        .in_mem_read_data   (in_mem_read_data),
        .in_mem_ready       (in_mem_ready)
`ifdef DCACHE_WB_STATS_EN
        ,
        .out_hit_count      (out_hit_count),
        .out_miss_count     (out_miss_count),
        .out_wb_count       (out_wb_count)
`endif
    );

    // Memory model: line L word w initialised to 0xA0000000 + L*16 + w.
    logic [127:0] mem [256];
    logic         busy;
    logic         is_wr;
    int           cnt;
    int           n_rd_req = 0;
    int           n_wr_req = 0;
    int           spurious = 0;
    logic [31:0]  last_rd_addr = 32'h0;
    logic [31:0]  last_wr_addr = 32'h0;
    logic [127:0] last_wr_data = 128'h0;

    initial begin
        for (int l = 0; l < 256; l++) begin
            for (int w = 0; w < 4; w++) begin
                mem[l][32*w +: 32] = 32'hA000_0000 + 32'(l * 16 + w);
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            in_mem_ready <= 1'b0;
            cnt          <= 0;
            is_wr        <= 1'b0;
        end else begin
            if ((in_mem_ready && (out_mem_read_en || out_mem_write_en)) ||
                (out_mem_read_en && out_mem_write_en))
                spurious <= spurious + 1;
            if (in_mem_ready) begin
                in_mem_ready <= 1'b0;
            end else if (!busy) begin
                if (out_mem_read_en || out_mem_write_en) begin
                    busy  <= 1'b1;
                    cnt   <= 0;
                    is_wr <= out_mem_write_en;
                    if (out_mem_write_en) n_wr_req <= n_wr_req + 1;
                    else                  n_rd_req <= n_rd_req + 1;
                end
            end else if (cnt == LAT - 2) begin
                busy         <= 1'b0;
                in_mem_ready <= 1'b1;
                if (is_wr) begin
                    mem[out_mem_addr[11:4]] <= out_mem_write_data;
                    last_wr_addr            <= out_mem_addr;
                    last_wr_data            <= out_mem_write_data;
                end else begin
                    in_mem_read_data <= mem[out_mem_addr[11:4]];
                    last_rd_addr     <= out_mem_addr;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one request from a negedge, wait for the stall to clear, return load data.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic first_stall);
        int n;
        in_read_en    = rd;
        in_write_en   = wr;
        in_addr       = addr;
        in_write_data = wdata;
        in_byte_en    = be;
        #1;
        first_stall = out_stall;
        n = 0;
        while (out_stall && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("stall_timeout", 128'(out_stall), 128'(0));
        rdata = out_read_data;
        @(negedge clk);
        in_read_en  = 1'b0;
        in_write_en = 1'b0;
    endtask

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [3:0]   be;
        logic         chk_data;
        logic [31:0]  exp_data;
        logic         exp_stall;
        int           exp_rd;
        int           exp_wr;
        logic [31:0]  exp_rd_addr;
        logic [31:0]  exp_wr_addr;
        logic [127:0] exp_wr_data;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdata;
        logic        st;
        int          rd0;
        int          wr0;

        vecs[0]  = '{1, 0, 32'h100, 0, 0, 1, 32'hA000_0100, 1, 1, 0, 32'h100, 0, 0};
        vecs[1]  = '{1, 0, 32'h10C, 0, 0, 1, 32'hA000_0103, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 32'h104, 32'hAABB_CCDD, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, 32'h104, 0, 0, 1, 32'hA000_CCDD, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 32'h200, 0, 0, 1, 32'hA000_0200, 1, 1, 1, 32'h200, 32'h100,
                     {32'hA000_0103, 32'hA000_0102, 32'hA000_CCDD, 32'hA000_0100}};
        vecs[5]  = '{0, 1, 32'h340, 32'h1122_3344, 4'b1111, 0, 0, 1, 1, 0, 32'h340, 0, 0};
        vecs[6]  = '{1, 0, 32'h344, 0, 0, 1, 32'hA000_0341, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{1, 0, 32'h440, 0, 0, 1, 32'hA000_0440, 1, 1, 1, 32'h440, 32'h340,
                     {32'hA000_0343, 32'hA000_0342, 32'hA000_0341, 32'h1122_3344}};
        vecs[8]  = '{1, 0, 32'h100, 0, 0, 1, 32'hA000_0100, 1, 1, 0, 32'h100, 0, 0};
        vecs[9]  = '{1, 0, 32'h104, 0, 0, 1, 32'hA000_CCDD, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{1, 1, 32'h108, 32'h5566_7788, 4'b1100, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 0, 32'h108, 0, 0, 1, 32'h5566_0102, 0, 0, 0, 0, 0, 0};

        reset         = 1'b1;
        in_read_en    = 1'b1;
        in_write_en   = 1'b0;
        in_addr       = 32'h100;
        in_write_data = 32'h0;
        in_byte_en    = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 128'(out_stall), 128'(0));
        chk("rst_rdata", 128'(out_read_data), 128'(0));
        chk("rst_mem_rd_en", 128'(out_mem_read_en), 128'(0));
        @(negedge clk);
        reset      = 1'b0;
        in_read_en = 1'b0;
        #1;
        chk("idle_stall", 128'(out_stall), 128'(0));
        chk("idle_mem_wr_en", 128'(out_mem_write_en), 128'(0));
        chk("idle_mem_addr", 128'(out_mem_addr), 128'(0));
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            rd0 = n_rd_req;
            wr0 = n_wr_req;
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rdata, st);
            chk($sformatf("v%0d_stall", i), 128'(st), 128'(vecs[i].exp_stall));
            if (vecs[i].chk_data)
                chk($sformatf("v%0d_rdata", i), 128'(rdata), 128'(vecs[i].exp_data));
            chk($sformatf("v%0d_rd_reqs", i), 128'(n_rd_req - rd0), 128'(vecs[i].exp_rd));
            chk($sformatf("v%0d_wr_reqs", i), 128'(n_wr_req - wr0), 128'(vecs[i].exp_wr));
            if (vecs[i].exp_rd > 0)
                chk($sformatf("v%0d_rd_addr", i), 128'(last_rd_addr), 128'(vecs[i].exp_rd_addr));
            if (vecs[i].exp_wr > 0) begin
                chk($sformatf("v%0d_wr_addr", i), 128'(last_wr_addr), 128'(vecs[i].exp_wr_addr));
                chk($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].exp_wr_data);
            end
            chk($sformatf("v%0d_handshake", i), 128'(spurious), 128'(0));
        end

        chk("mem_line_0x100", mem[8'h10],
            {32'hA000_0103, 32'hA000_0102, 32'hA000_CCDD, 32'hA000_0100});

`ifdef DCACHE_WB_STATS_EN
        chk("stat_hits", 128'(out_hit_count), 128'(7));
        chk("stat_misses", 128'(out_miss_count), 128'(5));
        chk("stat_wbs", 128'(out_wb_count), 128'(2));
`endif

        // Reset asserted in the middle of a refill.
        in_read_en = 1'b1;
        in_addr    = 32'h560;
        repeat (3) @(negedge clk);
        #1;
        chk("refill_rd_en", 128'(out_mem_read_en), 128'(1));
        chk("refill_addr", 128'(out_mem_addr), 128'(32'h560));
        reset = 1'b1;
        #1;
        chk("midrst_rd_en", 128'(out_mem_read_en), 128'(0));
        chk("midrst_wr_en", 128'(out_mem_write_en), 128'(0));
        chk("midrst_stall", 128'(out_stall), 128'(0));
        chk("midrst_addr", 128'(out_mem_addr), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        rd0 = n_rd_req;
        wr0 = n_wr_req;
        do_req(1'b1, 1'b0, 32'h560, 32'h0, 4'h0, rdata, st);
        chk("rerefill_stall", 128'(st), 128'(1));
        chk("rerefill_rdata", 128'(rdata), 128'(32'hA000_0560));
        chk("rerefill_rd_reqs", 128'(n_rd_req - rd0), 128'(1));
        chk("rerefill_wr_reqs", 128'(n_wr_req - wr0), 128'(0));
        chk("rerefill_handshake", 128'(spurious), 128'(0));

`ifdef DCACHE_WB_STATS_EN
        chk("stat_after_rst_misses", 128'(out_miss_count), 128'(1));
        chk("stat_after_rst_hits", 128'(out_hit_count), 128'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
